// File: rtl/seg7_scan_arbiter.sv
// Shared 4-digit seven-segment controller: two producers write a 4-entry frame buffer, a scan engine multiplexes it.
// Latency: write commits on the edge a request is granted (ack the cycle after); display updates at the next scan slot.
// Backpressure: req/ack handshake, round-robin grant of one write per cycle; the loser keeps req high until acked.
//
// Ports:
//   clk, rst                      - system clock, synchronous active-high reset
//   a_req/a_digit/a_pattern/a_ack - producer A write request, target digit, pattern, one-cycle commit pulse
//   b_req/b_digit/b_pattern/b_ack - producer B, same as A
//   blank                         - darkens the display at the next scan slot; scanning continues
//   seg7_sel, seg7                - one-hot digit enable and segment drive of the scanned digit
//   frame_done                    - one-cycle pulse after digit 3 has been loaded
module seg7_scan_arbiter #(
    parameter int SCAN_DIV = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic [1:0] a_digit,
    input  logic [7:0] a_pattern,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [1:0] b_digit,
    input  logic [7:0] b_pattern,
    output logic       b_ack,
    input  logic       blank,
    output logic [3:0] seg7_sel,
    output logic [7:0] seg7,
    output logic       frame_done
);

    localparam int            CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(SCAN_DIV - 1);

    // Encoding of the last_grant register.
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [1:0]    idx;
    logic [7:0]    frame_buf [4];
    logic          last_grant;
    logic          a_elig;
    logic          b_elig;
    logic          grant_a;
    logic          grant_b;

    always_comb begin
        // A requester whose ack is high this cycle is still holding the
        // request it just had committed; ignoring it prevents a double write.
        a_elig  = a_req & ~a_ack;
        b_elig  = b_req & ~b_ack;
        // On a tie the requester not served last time wins.
        grant_a = a_elig & (~b_elig | (last_grant == GRANT_B));
        grant_b = b_elig & ~grant_a;
        tick    = (tick_cnt == TICK_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            idx        <= 2'd0;
            last_grant <= GRANT_B;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            seg7_sel   <= 4'b0000;
            seg7       <= 8'h00;
            frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                frame_buf[i] <= 8'h00;
            end
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);

            a_ack <= grant_a;
            b_ack <= grant_b;
            if (grant_a) begin
                frame_buf[a_digit] <= a_pattern;
                last_grant         <= GRANT_A;
            end else if (grant_b) begin
                frame_buf[b_digit] <= b_pattern;
                last_grant         <= GRANT_B;
            end

            // The scan reads frame_buf before this edge's write lands, so a
            // write to the digit being loaded shows up one frame later.
            frame_done <= tick && (idx == 2'd3);
            if (tick) begin
                if (blank) begin
                    seg7_sel <= 4'b0000;
                    seg7     <= 8'h00;
                end else begin
                    seg7_sel <= 4'b0001 << idx;
                    seg7     <= frame_buf[idx];
                end
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_arbiter.sv
module tb_seg7_scan_arbiter;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       a_req, b_req;
    logic [1:0] a_digit, b_digit;
    logic [7:0] a_pattern, b_pattern;
    logic       a_ack, b_ack;
    logic       blank;
    logic [3:0] seg7_sel;
    logic [7:0] seg7;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    seg7_scan_arbiter #(.SCAN_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_req      (a_req),
        .a_digit    (a_digit),
        .a_pattern  (a_pattern),
        .a_ack      (a_ack),
        .b_req      (b_req),
        .b_digit    (b_digit),
        .b_pattern  (b_pattern),
        .b_ack      (b_ack),
        .blank      (blank),
        .seg7_sel   (seg7_sel),
        .seg7       (seg7),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Cycle counter since reset decides ticks; the display is a snapshot of
    // the digit array taken before the same edge's write.
    int         m_cnt;
    int         m_idx;
    logic [7:0] m_buf [4];
    bit         m_last_b;
    logic       m_a_ack, m_b_ack, m_fd;
    logic [3:0] m_sel;
    logic [7:0] m_seg;
    bit         ea, eb, ga, gb;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_last_b = 1;
            m_a_ack = 0; m_b_ack = 0; m_fd = 0;
            m_sel = 4'b0; m_seg = 8'h00;
            for (int i = 0; i < 4; i++) m_buf[i] = 8'h00;
        end else begin
            ea = a_req && !m_a_ack;
            eb = b_req && !m_b_ack;
            ga = ea && (!eb || m_last_b);
            gb = eb && !ga;
            m_fd = 0;
            if (m_cnt == DIV - 1) begin
                m_sel = blank ? 4'b0 : 4'(1 << m_idx);
                m_seg = blank ? 8'h00 : m_buf[m_idx];
                m_fd  = (m_idx == 3);
                m_idx = (m_idx + 1) % 4;
            end
            if (ga) begin m_buf[a_digit] = a_pattern; m_last_b = 0; end
            else if (gb) begin m_buf[b_digit] = b_pattern; m_last_b = 1; end
            m_a_ack = ga;
            m_b_ack = gb;
            m_cnt = (m_cnt + 1) % DIV;
        end
    end

    // Two cycles of reset; returns at the negedge where rst has just dropped.
    task automatic do_reset;
        @(negedge clk);
        rst = 1; a_req = 0; b_req = 0; blank = 0;
        a_digit = 0; b_digit = 0; a_pattern = 0; b_pattern = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset;
        int fd_cnt;
        logic [3:0] exp_sel;
        do_reset();
        if ({seg7_sel, seg7, a_ack, b_ack, frame_done} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs: got sel=%b seg=%h acks=%b%b fd=%b, want all 0",
                     seg7_sel, seg7, a_ack, b_ack, frame_done);
        end
        checks++;
        fd_cnt = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            exp_sel = (c < DIV) ? 4'b0 : 4'(1 << (((c / DIV) - 1) % 4));
            if (seg7_sel !== exp_sel || seg7 !== 8'h00) begin
                errors++;
                $display("FAIL reset_scan c=%0d: got sel=%b seg=%h, want sel=%b seg=00",
                         c, seg7_sel, seg7, exp_sel);
            end
            checks++;
            if (frame_done === 1'b1) fd_cnt++;
        end
        if (fd_cnt !== 2) begin
            errors++;
            $display("FAIL reset_frame_done: got %0d pulses in 32 cycles, want 2", fd_cnt);
        end
        checks++;
    endtask

    task automatic test_single_write;
        int seen;
        do_reset();
        a_req = 1; a_digit = 2; a_pattern = 8'h61;
        @(negedge clk);
        if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: got a_ack=%b b_ack=%b, want 1 0", a_ack, b_ack);
        end
        checks++;
        a_req = 0;
        seen = 0;
        for (int c = 2; c <= 24; c++) begin
            @(negedge clk);
            if (a_ack !== 1'b0) begin
                errors++;
                $display("FAIL single_ack_once c=%0d: got a_ack=%b, want 0", c, a_ack);
            end
            checks++;
            if (seg7_sel == 4'b0100) begin
                seen++;
                if (seg7 !== 8'h61) begin
                    errors++;
                    $display("FAIL single_digit2: got %h, want 61", seg7);
                end
                checks++;
            end else if (seg7 !== 8'h00) begin
                errors++;
                $display("FAIL single_other sel=%b: got %h, want 00", seg7_sel, seg7);
            end
        end
        if (seen == 0) begin
            errors++;
            $display("FAIL single_scan_reached: digit 2 never selected, want selected");
        end
        checks++;
    endtask

    task automatic test_alternate;
        do_reset();
        a_req = 1; a_digit = 0; a_pattern = 8'h01;
        b_req = 1; b_digit = 1; b_pattern = 8'h40;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (a_ack !== 1'(k % 2) || b_ack !== 1'(1 - (k % 2))) begin
                errors++;
                $display("FAIL alternate k=%0d: got a_ack=%b b_ack=%b, want %0d %0d",
                         k, a_ack, b_ack, k % 2, 1 - (k % 2));
            end
            checks++;
        end
        a_req = 0; b_req = 0;
    endtask

    task automatic test_same_digit;
        int seen;
        do_reset();
        a_req = 1; a_digit = 3; a_pattern = 8'h0C;
        b_req = 1; b_digit = 3; b_pattern = 8'h03;
        @(negedge clk);
        if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
            errors++;
            $display("FAIL same_first: got a_ack=%b b_ack=%b, want 1 0", a_ack, b_ack);
        end
        checks++;
        a_req = 0;
        @(negedge clk);
        if (a_ack !== 1'b0 || b_ack !== 1'b1) begin
            errors++;
            $display("FAIL same_second: got a_ack=%b b_ack=%b, want 0 1", a_ack, b_ack);
        end
        checks++;
        b_req = 0;
        seen = 0;
        for (int c = 3; c <= 20; c++) begin
            @(negedge clk);
            if (seg7_sel == 4'b1000) begin
                seen++;
                if (seg7 !== 8'h03) begin
                    errors++;
                    $display("FAIL same_last_wins: got %h, want 03", seg7);
                end
                checks++;
            end
        end
        if (seen == 0) begin
            errors++;
            $display("FAIL same_scan_reached: digit 3 never selected, want selected");
        end
        checks++;
    endtask

    task automatic test_read_before_write;
        do_reset();
        @(negedge clk); @(negedge clk); @(negedge clk);   // c = 3
        a_req = 1; a_digit = 0; a_pattern = 8'h5A;
        @(negedge clk);                                   // c = 4: tick + write same edge
        if (seg7_sel !== 4'b0001 || seg7 !== 8'h00 || a_ack !== 1'b1) begin
            errors++;
            $display("FAIL rbw_old: got sel=%b seg=%h a_ack=%b, want 0001 00 1",
                     seg7_sel, seg7, a_ack);
        end
        checks++;
        a_req = 0;
        for (int c = 5; c <= 20; c++) @(negedge clk);
        if (seg7_sel !== 4'b0001 || seg7 !== 8'h5A) begin
            errors++;
            $display("FAIL rbw_new: got sel=%b seg=%h, want 0001 5a", seg7_sel, seg7);
        end
        checks++;
    endtask

    task automatic test_blank_reset;
        int fd_cnt;
        blank = 1;
        for (int c = 0; c < DIV; c++) @(negedge clk);
        fd_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (seg7_sel !== 4'b0 || seg7 !== 8'h00) begin
                errors++;
                $display("FAIL blank_dark: got sel=%b seg=%h, want 0000 00", seg7_sel, seg7);
            end
            checks++;
            if (frame_done === 1'b1) fd_cnt++;
        end
        if (fd_cnt < 1) begin
            errors++;
            $display("FAIL blank_frame_done: got %0d pulses, want at least 1", fd_cnt);
        end
        checks++;
        // mid-scan reset with fresh requests pending
        rst = 1; a_req = 1; a_digit = 1; a_pattern = 8'hFF;
        b_req = 1; b_digit = 2; b_pattern = 8'hEE;
        @(negedge clk);
        if ({seg7_sel, seg7, a_ack, b_ack, frame_done} !== 15'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got sel=%b seg=%h acks=%b%b fd=%b, want all 0",
                     seg7_sel, seg7, a_ack, b_ack, frame_done);
        end
        checks++;
        rst = 0; a_req = 0; b_req = 0; blank = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c < DIV && seg7_sel !== 4'b0) begin
                errors++;
                $display("FAIL midreset_early_tick c=%0d: got sel=%b, want 0000", c, seg7_sel);
            end
            if (c == DIV && seg7_sel !== 4'b0001) begin
                errors++;
                $display("FAIL midreset_first_tick: got sel=%b, want 0001", seg7_sel);
            end
            if (seg7 !== 8'h00 || a_ack !== 1'b0 || b_ack !== 1'b0) begin
                errors++;
                $display("FAIL midreset_cleared c=%0d: got seg=%h acks=%b%b, want 00 00",
                         c, seg7, a_ack, b_ack);
            end
            checks++;
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ({seg7_sel, seg7, a_ack, b_ack, frame_done} !==
                {m_sel, m_seg, m_a_ack, m_b_ack, m_fd}) begin
                errors++;
                $display("FAIL random k=%0d: got sel=%b seg=%h acks=%b%b fd=%b, want sel=%b seg=%h acks=%b%b fd=%b",
                         k, seg7_sel, seg7, a_ack, b_ack, frame_done,
                         m_sel, m_seg, m_a_ack, m_b_ack, m_fd);
            end
            checks++;
            // Producers hold a request until acked, then may drop or replace it.
            if (!a_req || a_ack) begin
                a_req     = ($urandom_range(0, 2) != 0);
                a_digit   = 2'($urandom_range(0, 3));
                a_pattern = 8'($urandom);
            end
            if (!b_req || b_ack) begin
                b_req     = ($urandom_range(0, 2) != 0);
                b_digit   = 2'($urandom_range(0, 3));
                b_pattern = 8'($urandom);
            end
            if ($urandom_range(0, 31) == 0) blank = ~blank;
        end
        a_req = 0; b_req = 0; blank = 0;
    endtask

    initial begin
        rst = 1; a_req = 0; b_req = 0; blank = 0;
        a_digit = 0; b_digit = 0; a_pattern = 0; b_pattern = 0;
        test_reset();
        test_single_write();
        test_alternate();
        test_same_digit();
        test_read_before_write();
        test_blank_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
